// File: rtl/div_unit.sv
// rtl/div_unit.sv - 32-bit signed/unsigned restoring divider, one quotient bit per cycle
module div_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] opa_i,
    input  logic [31:0] opb_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stall_div_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DIVZ = 2'd1;
    localparam logic [1:0] ON   = 2'd2;
    localparam logic [1:0] END  = 2'd3;

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [64:0] rq;
    logic [31:0] divisor;
    logic        neg_q;
    logic        neg_r;

    logic        neg_a;
    logic        neg_b;
    logic [31:0] opa_mag;
    logic [31:0] opb_mag;
    logic [33:0] rem_win;
    logic [32:0] diff;
    logic        ge;
    logic [64:0] step_rq;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    assign neg_a   = signed_i & opa_i[31];
    assign neg_b   = signed_i & opb_i[31];
    assign opa_mag = neg_a ? (~opa_i + 32'd1) : opa_i;
    assign opb_mag = neg_b ? (~opb_i + 32'd1) : opb_i;

    // The window includes rq[64] so the compare sees the bit shifted out; it is always 0
    // because the partial remainder stays below the 32-bit divisor.
    assign rem_win = rq[64:31];
    assign ge      = rem_win >= {2'b00, divisor};
    assign diff    = rq[63:31] - {1'b0, divisor};
    assign step_rq = ge ? {diff, rq[30:0], 1'b1} : {rq[63:0], 1'b0};

    assign q_fix = neg_q ? (~step_rq[31:0]  + 32'd1) : step_rq[31:0];
    assign r_fix = neg_r ? (~step_rq[63:32] + 32'd1) : step_rq[63:32];

    assign stall_div_o = start_i & ~ready_o & ~annul_i;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt      <= 6'd0;
            rq       <= 65'd0;
            divisor  <= 32'd0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
        end else begin
            ready_o <= 1'b0;
            if (annul_i) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            rq      <= {33'd0, opa_mag};
                            divisor <= opb_mag;
                            neg_q   <= neg_a ^ neg_b;
                            neg_r   <= neg_a;
                            cnt     <= 6'd0;
                            state   <= (opb_i == 32'd0) ? DIVZ : ON;
                        end
                    end
                    DIVZ: begin
                        result_o <= 64'd0;
                        ready_o  <= 1'b1;
                        state    <= END;
                    end
                    ON: begin
                        rq  <= step_rq;
                        cnt <= cnt + 6'd1;
                        // Sign fix-up is folded into the final step so END just presents it.
                        if (cnt == 6'd31) begin
                            result_o <= {r_fix, q_fix};
                            ready_o  <= 1'b1;
                            state    <= END;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit with directed vectors
module tb_div_unit;

    logic        clk;
    logic        resetn;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opa_i;
    logic [31:0] opb_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_div_o;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          last_ready_cyc = 0;
    logic [63:0] exp_q[$];

    div_unit dut (
        .clk         (clk),
        .resetn      (resetn),
        .start_i     (start_i),
        .signed_i    (signed_i),
        .opa_i       (opa_i),
        .opb_i       (opb_i),
        .annul_i     (annul_i),
        .result_o    (result_o),
        .ready_o     (ready_o),
        .stall_div_o (stall_div_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (resetn && ready_o) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ready: result=%h with no pending divide", result_o);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if (result_o !== e) begin
                    bad++;
                    $display("FAIL result: got %h expected %h", result_o, e);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at posedge+1; issues one divide, scrambles operands after the latch, measures timing.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input logic [63:0] exp, input int lat, input bit hold, input string nm);
        int stalls;
        int ready_at;
        opa_i    = a;
        opb_i    = b;
        signed_i = sgn;
        start_i  = 1'b1;
        exp_q.push_back(exp);
        stalls   = 0;
        ready_at = -1;
        for (int k = 0; k < lat + 6; k++) begin
            @(negedge clk);
            if (stall_div_o) stalls++;
            if (ready_o) begin
                ready_at       = k;
                last_ready_cyc = cyc;
                break;
            end
            if (k >= 1) begin
                opa_i    = $urandom;
                opb_i    = $urandom;
                signed_i = 1'($urandom_range(0, 1));
            end
        end
        check({nm, "_latency"}, 64'(ready_at), 64'(lat));
        check({nm, "_stalls"},  64'(stalls),   64'(lat));
        @(posedge clk);
        #1;
        if (!hold) start_i = 1'b0;
    endtask

    initial begin
        int first_cyc;
        int readies;
        resetn   = 1'b0;
        start_i  = 1'b0;
        signed_i = 1'b0;
        opa_i    = 32'd0;
        opb_i    = 32'd0;
        annul_i  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready",  64'(ready_o),     64'd0);
        check("reset_result", result_o,         64'd0);
        check("reset_stall",  64'(stall_div_o), 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        run_div(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33, 1'b0, "udiv_100_7");
        run_div(32'd5, 32'd0, 1'b0, 64'h0, 2, 1'b0, "divz");
        run_div(32'hFFFFFFF9, 32'h2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 33, 1'b0, "sdiv_m7_2");
        run_div(32'h7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 33, 1'b0, "sdiv_7_m2");
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 33, 1'b0, "sdiv_min_m1");

        // Annul at t+10: nothing completes, and a start at t+11 is accepted from IDLE.
        opa_i    = 32'd100;
        opb_i    = 32'd7;
        signed_i = 1'b0;
        start_i  = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        annul_i = 1'b1;
        @(negedge clk);
        check("annul_stall", 64'(stall_div_o), 64'd0);
        check("annul_ready", 64'(ready_o),     64'd0);
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        check("annul_result_held", result_o, 64'h00000000_80000000);
        check("annul_ready_after", 64'(ready_o), 64'd0);
        run_div(32'd1000, 32'd10, 1'b0, 64'h00000000_00000064, 33, 1'b0, "post_annul");

        // Annul overrides start while IDLE.
        start_i = 1'b1;
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        annul_i = 1'b0;
        readies = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ready_o) readies++;
        end
        check("annul_over_start", 64'(readies), 64'd0);
        @(posedge clk);
        #1;

        // Reset mid-divide clears outputs at once; stall still follows its inputs.
        opa_i    = 32'hFFFFFFFF;
        opb_i    = 32'h10;
        signed_i = 1'b0;
        start_i  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check("midreset_ready",  64'(ready_o),     64'd0);
        check("midreset_result", result_o,         64'd0);
        check("midreset_stall",  64'(stall_div_o), 64'd1);
        start_i = 1'b0;
        #1;
        check("midreset_stall_nostart", 64'(stall_div_o), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("inreset_ready", 64'(ready_o), 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        run_div(32'hFFFFFFFF, 32'h10, 1'b0, 64'h0000000F_0FFFFFFF, 33, 1'b1, "b2b_first");
        first_cyc = last_ready_cyc;
        run_div(32'hFFFFFFFF, 32'h10, 1'b0, 64'h0000000F_0FFFFFFF, 33, 1'b0, "b2b_second");
        check("b2b_gap", 64'(last_ready_cyc - first_cyc), 64'd34);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
